// File: rtl/seq_or_matcher.sv
// seq_or_matcher: two independent sequence threads started from one attempt.
// Thread A: a at t, b==1 at t+1, e==1 at t+2   -> match_a in t+3.
// Thread B: c at t, (none) t+1, d==2 at t+2, e==2 at t+3 -> match_b in t+4.
// Overlapping attempts are tracked with one-hot shift stages per thread;
// start/match/fail counters saturate and can be cleared independently.
module seq_or_matcher #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    a,
  input  logic                    c,
  input  logic signed [31:0]      b,
  input  logic signed [31:0]      d,
  input  logic signed [31:0]      e,
  output logic                    match_a,
  output logic                    match_b,
  output logic                    match,
  output logic [CNT_W-1:0]        match_cnt,
  output logic [CNT_W-1:0]        start_cnt,
  output logic [CNT_W-1:0]        fail_cnt
);

  localparam int unsigned OP_W  = 32;
  localparam int unsigned INC_W = 2;
  localparam int unsigned SUM_W = CNT_W + 1;

  // Per-thread local values; each thread only ever compares against its own.
  localparam logic signed [OP_W-1:0] V_A = 32'sd1;
  localparam logic signed [OP_W-1:0] V_B = 32'sd2;

  // Stage occupancy: a_s1 = thread A one cycle old, etc.
  logic a_s1, a_s2;
  logic b_s1, b_s2, b_s3;

  // Check results and per-stage outcomes for the current cycle.
  logic start_a, start_b;
  logic b_ok_a, e_ok_a, d_ok_b, e_ok_b;
  logic adv_a2, kill_a1, kill_a2, done_a;
  logic adv_b3, kill_b2, kill_b3, done_b;
  logic [INC_W-1:0] n_start, n_done, n_kill;

  // Saturating add of a 0..2 increment; never wraps past all-ones.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] cnt,
    input logic [INC_W-1:0] inc
  );
    logic [SUM_W-1:0] sum;
    sum = {1'b0, cnt} + SUM_W'(inc);
    if (sum[SUM_W-1]) begin
      return '1;
    end
    return sum[CNT_W-1:0];
  endfunction

  // Stage checks, kills and completions; full 32-bit signed equality.
  always_comb begin
    start_a = en & a;
    start_b = en & c;

    b_ok_a  = (b == V_A);
    e_ok_a  = (e == V_A);
    d_ok_b  = (d == V_B);
    e_ok_b  = (e == V_B);

    adv_a2  = a_s1 &  b_ok_a;
    kill_a1 = a_s1 & ~b_ok_a;
    done_a  = a_s2 &  e_ok_a;
    kill_a2 = a_s2 & ~e_ok_a;

    adv_b3  = b_s2 &  d_ok_b;
    kill_b2 = b_s2 & ~d_ok_b;
    done_b  = b_s3 &  e_ok_b;
    kill_b3 = b_s3 & ~e_ok_b;

    n_start = INC_W'(start_a) + INC_W'(start_b);
    n_done  = INC_W'(done_a)  + INC_W'(done_b);
    // Kills are counted at most once per thread kind per cycle.
    n_kill  = INC_W'(kill_a1 | kill_a2) + INC_W'(kill_b2 | kill_b3);
  end

  // Thread stage shift registers; reset discards in-flight attempts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
      b_s3 <= 1'b0;
    end else begin
      a_s1 <= start_a;
      a_s2 <= adv_a2;
      b_s1 <= start_b;
      b_s2 <= b_s1;
      b_s3 <= adv_b3;
    end
  end

  // Registered match pulses; unaffected by clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_a <= 1'b0;
      match_b <= 1'b0;
      match   <= 1'b0;
    end else begin
      match_a <= done_a;
      match_b <= done_b;
      match   <= done_a | done_b;
    end
  end

  // Event counters; clr zeroes them and overrides any increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      match_cnt <= '0;
      start_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      match_cnt <= sat_add(match_cnt, n_done);
      start_cnt <= sat_add(start_cnt, n_start);
      fail_cnt  <= sat_add(fail_cnt, n_kill);
    end
  end

endmodule
